// File: rtl/snoop_bus_arbiter.sv
// Round-robin arbiter for the shared snooping bus: grants one cache
// controller at a time, broadcasts its coherence op and waits out write-backs.
module snoop_bus_arbiter #(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 8,
  parameter int SRC_W   = 2
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset_n,
  input  logic [N_CORES-1:0]        i_Req,
  input  logic [2*N_CORES-1:0]      i_Op,
  input  logic [ADDR_W*N_CORES-1:0] i_Addr,
  input  logic [N_CORES-1:0]        i_Wb_Needed,
  input  logic                      i_Wb_Done,
  output logic                      o_Bus_Valid,
  output logic [1:0]                o_Bus_Op,
  output logic [ADDR_W-1:0]         o_Bus_Addr,
  output logic [SRC_W-1:0]          o_Bus_Src,
  output logic [N_CORES-1:0]        o_Grant,
  output logic [N_CORES-1:0]        o_Done
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BROADCAST = 2'd1,
    WAIT_WB   = 2'd2,
    COMPLETE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_RD   = 2'd0;
  localparam logic [1:0] OP_WR   = 2'd2;
  localparam logic [1:0] OP_NONE = 2'd3;

  state_t             state_q, state_d;
  logic [SRC_W-1:0]   ptr_q, ptr_d;
  logic [SRC_W-1:0]   sel, src_d;
  logic               found;
  int                 idx;
  logic [1:0]         sel_op, op_d;
  logic [ADDR_W-1:0]  addr_d;
  logic               valid_d;
  logic               miss;
  logic [N_CORES-1:0] grant_d, done_d;
  logic [N_CORES-1:0] wb, sel_hot, src_hot;

  // First requester at or above the pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int i = 0; i < N_CORES; i++) begin
      idx = (int'(ptr_q) + i) % N_CORES;
      if (!found && i_Req[idx]) begin
        found = 1'b1;
        sel   = SRC_W'(idx);
      end
    end
  end

  assign sel_op  = i_Op[2*int'(sel) +: 2];
  assign sel_hot = N_CORES'(1) << sel;
  assign src_hot = N_CORES'(1) << o_Bus_Src;
  assign wb      = i_Wb_Needed & ~o_Grant;
  assign miss    = (o_Bus_Op == OP_RD) || (o_Bus_Op == OP_WR);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    valid_d = 1'b0;
    op_d    = o_Bus_Op;
    addr_d  = o_Bus_Addr;
    src_d   = o_Bus_Src;
    grant_d = o_Grant;
    done_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          op_d   = sel_op;
          addr_d = i_Addr[ADDR_W*int'(sel) +: ADDR_W];
          src_d  = sel;
          if (sel_op == OP_NONE) begin
            state_d = COMPLETE;
            grant_d = '0;
            done_d  = sel_hot;
          end else begin
            state_d = BROADCAST;
            grant_d = sel_hot;
            valid_d = 1'b1;
          end
        end
      end
      BROADCAST: begin
        if (miss && |wb) begin
          state_d = WAIT_WB;
        end else begin
          state_d = COMPLETE;
          grant_d = '0;
          done_d  = src_hot;
        end
      end
      WAIT_WB: begin
        if (i_Wb_Done) begin
          state_d = COMPLETE;
          grant_d = '0;
          done_d  = src_hot;
        end
      end
      COMPLETE: begin
        state_d = IDLE;
        ptr_d   = SRC_W'((int'(o_Bus_Src) + 1) % N_CORES);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      o_Bus_Valid <= 1'b0;
      o_Bus_Op    <= '0;
      o_Bus_Addr  <= '0;
      o_Bus_Src   <= '0;
      o_Grant     <= '0;
      o_Done      <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      o_Bus_Valid <= valid_d;
      o_Bus_Op    <= op_d;
      o_Bus_Addr  <= addr_d;
      o_Bus_Src   <= src_d;
      o_Grant     <= grant_d;
      o_Done      <= done_d;
    end
  end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Bench for snoop_bus_arbiter: vector table with a bus/done scoreboard,
// plus hand sequences for reset, round-robin and write-back waits.
module tb_snoop_bus_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [2*N-1:0] op = '0;
  logic [AW*N-1:0] addr = '0;
  logic [N-1:0]  wbn = '0;
  logic          wbd = 1'b0;
  logic          bv;
  logic [1:0]    bop;
  logic [AW-1:0] baddr;
  logic [SW-1:0] bsrc;
  logic [N-1:0]  grant;
  logic [N-1:0]  done;

  snoop_bus_arbiter #(.N_CORES(N), .ADDR_W(AW), .SRC_W(SW)) dut (
    .i_Clock     (clk),
    .i_Reset_n   (rst_n),
    .i_Req       (req),
    .i_Op        (op),
    .i_Addr      (addr),
    .i_Wb_Needed (wbn),
    .i_Wb_Done   (wbd),
    .o_Bus_Valid (bv),
    .o_Bus_Op    (bop),
    .o_Bus_Addr  (baddr),
    .o_Bus_Src   (bsrc),
    .o_Grant     (grant),
    .o_Done      (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  addr;
    logic [1:0]  src;
  } bus_t;

  typedef struct {
    logic [3:0] req;
    logic [1:0] op;
    logic [7:0] addr;
    logic [3:0] wb;
    int         dly;
    bit         wait_wb;
  } vec_t;

  bus_t       bq[$];
  logic [1:0] dq[$];
  bit         mon_en = 1'b0;
  bus_t       me;
  logic [1:0] ms;
  vec_t       tbl[8];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bv) begin
        if (bq.size() == 0) begin
          check("bus_unexpected", 32'd1, 32'd0);
        end else begin
          me = bq.pop_front();
          check("bus_op", 32'(bop), 32'(me.op));
          check("bus_addr", 32'(baddr), 32'(me.addr));
          check("bus_src", 32'(bsrc), 32'(me.src));
          check("bus_grant", 32'(grant), 32'(1) << me.src);
        end
      end
      if (done != 0) begin
        if (dq.size() == 0) begin
          check("done_unexpected", 32'(done), 32'd0);
        end else begin
          ms = dq.pop_front();
          check("done_onehot", 32'(done), 32'(1) << ms);
        end
      end
    end
  end

  task automatic run_txn(input vec_t v);
    int   src;
    int   cyc;
    int   dcyc;
    bit   seen;
    bus_t be;
    src = 0;
    for (int k = 0; k < N; k++) if (v.req[k]) src = k;
    @(negedge clk);
    req  = v.req;
    op   = {N{v.op}};
    addr = $urandom;
    addr[AW*src +: AW] = v.addr;
    wbn  = v.wb;
    if (v.op != 2'd3) begin
      be.op   = v.op;
      be.addr = v.addr;
      be.src  = 2'(src);
      bq.push_back(be);
    end
    dq.push_back(2'(src));
    cyc  = 0;
    seen = 1'b0;
    dcyc = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (v.wait_wb && cyc == 2) begin
        check("wait_valid_low", 32'(bv), 32'd0);
        check("wait_grant", 32'(grant), 32'(1) << src);
      end
      if (done != 0) begin
        seen = 1'b1;
        dcyc = cyc;
        check("done_grant_clear", 32'(grant), 32'd0);
        wbd = 1'b0;
        req = '0;
      end else if (v.wait_wb && cyc == 1 + v.dly) begin
        wbd = 1'b1;
      end
    end
    wbd = 1'b0;
    req = '0;
    if (!seen)
      check("done_timeout", 32'd0, 32'd1);
    else if (v.op == 2'd3)
      check("nothing_latency", 32'(dcyc inside {[1:2]}), 32'd1);
    else
      check("done_latency", 32'(dcyc), 32'(v.wait_wb ? 2 + v.dly : 2));
    @(negedge clk);
    check("queues_drained", 32'(bq.size() + dq.size()), 32'd0);
    bq.delete();
    dq.delete();
  endtask

  task automatic seq_reset_rr();
    int cnt;
    int cyc;
    int last;
    @(negedge clk);
    req  = 4'b0100;
    op   = '0;
    addr = '0;
    addr[AW*2 +: AW] = 8'h3C;
    wbn  = '0;
    @(negedge clk);
    check("pre_reset_valid", 32'(bv), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_bcast", 32'({bv, bop, baddr, bsrc, grant, done}), 32'd0);
    req  = 4'b1111;
    addr = {8'h13, 8'h12, 8'h11, 8'h10};
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt  = 0;
    cyc  = 0;
    last = 0;
    while (cnt < 5 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bv) begin
        check("rr_src", 32'(bsrc), 32'(cnt % 4));
        check("rr_addr", 32'(baddr), 32'(8'h10 + cnt % 4));
        if (cnt > 0) check("rr_spacing", 32'(cyc - last), 32'd3);
        last = cyc;
        cnt++;
      end
    end
    if (cnt < 5) check("rr_timeout", 32'(cnt), 32'd5);
    req = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic seq_reset_wait();
    bit any_done;
    @(negedge clk);
    req  = 4'b0010;
    op   = {N{2'd2}};
    addr = 32'h44332211;
    wbn  = 4'b1010;
    @(negedge clk);
    check("b_valid_src", 32'({bv, bsrc}), 32'({1'b1, 2'd1}));
    @(negedge clk);
    check("b_in_wait", 32'({bv, grant}), 32'({1'b0, 4'b0010}));
    #2 rst_n = 1'b0;
    #1 check("async_reset_wait", 32'({bv, bop, baddr, bsrc, grant, done}), 32'd0);
    req = 4'b0011;
    @(negedge clk);
    rst_n = 1'b1;
    wbd   = 1'b1;
    @(negedge clk);
    wbd = 1'b0;
    check("regrant_core0", 32'({bv, bsrc, baddr}), 32'({1'b1, 2'd0, 8'h11}));
    any_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done != 0) any_done = 1'b1;
    end
    check("stale_wb_ignored", 32'(any_done), 32'd0);
    wbd = 1'b1;
    @(negedge clk);
    wbd = 1'b0;
    check("wb_done_complete", 32'(done), 32'h1);
    req = '0;
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{4'b0100, 2'd0, 8'h3C, 4'b0000, 0, 1'b0};
    tbl[1] = '{4'b0010, 2'd2, 8'hA5, 4'b1010, 3, 1'b1};
    tbl[2] = '{4'b0010, 2'd2, 8'h5A, 4'b0010, 0, 1'b0};
    tbl[3] = '{4'b1000, 2'd1, 8'h77, 4'b1111, 0, 1'b0};
    tbl[4] = '{4'b0001, 2'd3, 8'h11, 4'b0000, 0, 1'b0};
    tbl[5] = '{4'b0001, 2'd0, 8'h0F, 4'b0100, 1, 1'b1};
    tbl[6] = '{4'b1000, 2'd2, 8'hFF, 4'b0000, 0, 1'b0};
    tbl[7] = '{4'b0100, 2'd1, 8'h00, 4'b0000, 0, 1'b0};

    #12;
    check("reset_outputs", 32'({bv, bop, baddr, bsrc, grant, done}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 8; i++) run_txn(tbl[i]);
    mon_en = 1'b0;

    seq_reset_rr();
    seq_reset_wait();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
